// File: rtl/sram_frame_writer.sv
// sram_frame_writer: read-modify-write of one SRAM word per received pixel byte
module sram_frame_writer #(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 16,
  parameter int WAIT_CYCLES = 4,
  parameter int FRAME_WORDS = 240000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_valid,
  input  logic                  msg_start,
  input  logic                  enable,
  output logic                  busy,
  output logic                  overflow,
  output logic [ADDR_WIDTH-1:0] words_written,
  output logic                  mem_ce_n,
  output logic                  mem_read_n,
  output logic                  mem_write_n,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t state, state_n;
  logic accept;
  logic restart;
  logic [3:0] wait_cnt;
  logic [7:0] cur_byte;
  logic [ADDR_WIDTH-1:0] pointer;
  assign words_written = pointer;
  // next state; a byte is taken only when idle, enabled and not restarting the frame
  always_comb begin
    accept = state == IDLE && rx_valid && enable && !msg_start;
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = READ;
      READ:    if (wait_cnt == 4'd0) state_n = WRITE;
      WRITE:   state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  // strobes are decoded from the next state so they are registered and align with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_ce_n <= 1'b1;
      mem_read_n <= 1'b1;
      mem_write_n <= 1'b1;
      mem_addr <= '0;
      mem_wdata <= '0;
      busy <= 1'b0;
      overflow <= 1'b0;
      pointer <= '0;
      cur_byte <= '0;
      wait_cnt <= '0;
      restart <= 1'b0;
    end else begin
      mem_ce_n <= !(state_n == READ || state_n == WRITE);
      mem_read_n <= state_n != READ;
      mem_write_n <= state_n != WRITE;
      busy <= state_n != IDLE;
      overflow <= msg_start ? 1'b0 : overflow | (rx_valid & enable & (state != IDLE));
      restart <= state_n != IDLE && (restart || msg_start);
      if (accept) begin
        cur_byte <= rx_byte;
        mem_addr <= pointer;
        wait_cnt <= 4'(WAIT_CYCLES - 1);
      end else if (state == READ) wait_cnt <= wait_cnt - 4'd1;
      if (state == READ && wait_cnt == 4'd0) mem_wdata <= (mem_rdata << 8) | DATA_WIDTH'(cur_byte);
      if (msg_start) pointer <= '0;
      else if (state == DONE && !restart) pointer <= pointer == ADDR_WIDTH'(FRAME_WORDS - 1) ? '0 : pointer + 1'b1;
    end
  end
endmodule

// File: doc/sram_frame_writer.md
# sram_frame_writer

Frame-buffer write stage between the SPI slave and the asynchronous SRAM interface. Consumes the received SPI byte stream of a WRITE command and turns each byte into a read-modify-write of one 16-bit SRAM word. The new pixel byte goes into the low byte. The previous low byte, read back from the same word, moves to the high byte. The panel driver downstream then holds both the current and the previous frame for waveform lookup.

## Interface
Parameters:
- ADDR_WIDTH, 18, SRAM word-address width.
- DATA_WIDTH, 16, SRAM data width; fixed as two bytes (high = previous, low = current).
- WAIT_CYCLES, 4, number of cycles the SRAM read strobe is held before read data is sampled; legal range 1..15.
- FRAME_WORDS, 240000, number of words in one frame; the address pointer wraps after FRAME_WORDS-1.

Ports (clock and reset first):
- clk  in  1  system clock; every register uses its rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_byte  in  8  SPI received byte; valid when rx_valid is high.
- rx_valid  in  1  one-cycle pulse: rx_byte holds a new payload byte.
- msg_start  in  1  one-cycle pulse at SPI select assertion; restarts the frame.
- enable  in  1  high while the active command is WRITE and the panel driver is ready.
- busy  out  1  high while a read-modify-write is in progress.
- overflow  out  1  sticky; a byte arrived while busy and was dropped.
- words_written  out  ADDR_WIDTH  current address pointer (words completed in this frame, modulo FRAME_WORDS).
- mem_ce_n  out  1  SRAM chip enable, active low.
- mem_read_n  out  1  SRAM read strobe, active low.
- mem_write_n  out  1  SRAM write strobe, active low.
- mem_addr  out  ADDR_WIDTH  SRAM word address.
- mem_wdata  out  DATA_WIDTH  SRAM write data.
- mem_rdata  in  DATA_WIDTH  SRAM read data.

## Operation
- All outputs are registered.
- Reset values:
  - mem_ce_n, mem_read_n, mem_write_n = 1.
  - mem_addr, mem_wdata, words_written = 0.
  - busy = 0, overflow = 0.
  - state = IDLE.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - All strobes are high.
  - If rx_valid && enable && !msg_start: latch rx_byte into cur_byte.
  - Drive mem_addr = pointer.
  - Go to READ and load wait_cnt = WAIT_CYCLES-1.
- READ:
  - mem_ce_n = 0, mem_read_n = 0, mem_write_n = 1.
  - wait_cnt decrements each cycle.
  - When wait_cnt == 0: capture prev_byte = mem_rdata[7:0], then go to WRITE.
- WRITE (exactly one cycle):
  - mem_ce_n = 0, mem_read_n = 1, mem_write_n = 0.
  - mem_wdata = {prev_byte, cur_byte}; mem_addr is unchanged.
  - Go to DONE.
- DONE (one cycle):
  - All strobes go high; mem_wdata and mem_addr are held.
  - pointer = (pointer == FRAME_WORDS-1) ? 0 : pointer+1.
  - Go to IDLE.
- busy is high in READ, WRITE and DONE.
- rx_valid while busy: the byte is dropped and overflow is set. The current operation is unaffected.
- rx_valid while enable = 0: ignored; overflow is not set.
- msg_start:
  - Clears pointer and overflow.
  - In the same cycle as rx_valid, msg_start wins and the byte is ignored.
  - During READ or WRITE, the operation completes to the old address. The DONE increment is suppressed, so pointer stays 0.
- enable falling mid-operation: the current read-modify-write completes; no abort.
- rst mid-operation: strobes go high immediately (asynchronously); no partial write survives beyond the reset edge.

## Timing
- Cycle 0: rx_valid is sampled.
- Cycles 1..WAIT_CYCLES: READ.
  - mem_addr is stable from cycle 1.
  - mem_rdata is sampled at the end of cycle WAIT_CYCLES.
- Cycle WAIT_CYCLES+1: WRITE.
  - mem_write_n is low for exactly one cycle.
  - mem_addr and mem_wdata are stable the whole cycle and in the following DONE cycle.
- Cycle WAIT_CYCLES+2: DONE; pointer updates at the end of this cycle.
- Cycle WAIT_CYCLES+3: IDLE again. A new rx_valid is accepted in this cycle or later.
- busy spans cycles 1..WAIT_CYCLES+2.
- Sustained throughput: one byte per WAIT_CYCLES+3 cycles (7 at the default).
- mem_read_n and mem_write_n are never low in the same cycle. There is always one cycle with both high between a WRITE and the next READ.

## Test plan
- Single byte, default parameters:
  - Stimulus: reset, enable = 1, memory word 0 preloaded with 0x00AB, rx_byte = 0x5C pulsed.
  - Required: mem_read_n low for 4 cycles at addr 0, then mem_write_n low for 1 cycle with wdata = 0xAB5C, then words_written = 1, busy low 7 cycles after the pulse.
- Burst overflow:
  - Stimulus: two rx_valid pulses 3 cycles apart.
  - Required: only the first byte is written and overflow = 1.
  - Then pulse msg_start: overflow = 0 and words_written = 0.
- Wrap:
  - Stimulus: FRAME_WORDS = 4; send 5 bytes spaced 8 cycles apart.
  - Required: writes go to addresses 0, 1, 2, 3, 0; final words_written = 1.
- Gating:
  - Stimulus: enable = 0 with rx_valid pulsed.
  - Required: no strobe activity and overflow stays 0.
  - Also: msg_start and rx_valid in the same cycle gives no write.
- Reset mid-write:
  - Stimulus: assert rst during the WRITE cycle.
  - Required: mem_write_n and mem_ce_n go high before the next clock edge; all outputs at reset values.
- Slow SRAM:
  - Stimulus: WAIT_CYCLES = 1, the model changes rdata every cycle.
  - Required: prev_byte equals the rdata present in cycle 1 and the write lands in cycle 2.
